// File: rtl/spi_reg_pkg.sv
// Shared encodings for the SPI register-bank command layer.
package spi_reg_pkg;

    localparam int CMD_RW_BIT   = 7;
    localparam int CMD_ADDR_MSB = 6;
    localparam int ADDR_W       = 7;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_WRITE,
        ST_READ,
        ST_IGNORE
    } state_e;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser; resets to 1 so an idle chip select reads as deasserted.
module sync_2ff (
    input  logic Clock,
    input  logic Reset,
    input  logic d_i,
    output logic q_o
);

    logic meta_q, sync_q;

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/spi_reg_bank.sv
// Command layer behind the SPI byte engine: auto-incrementing register
// writes/reads framed by chip select, plus a fabric-side write port.
module spi_reg_bank
    import spi_reg_pkg::*;
#(
    parameter int          REG_COUNT = 16,
    parameter logic [7:0]  ID_BYTE   = 8'hA5,
    parameter logic [7:0]  OOR_BYTE  = 8'hFF
) (
    input  logic                   Clock,
    input  logic                   Reset,
    input  logic                   CS_i,
    input  logic                   Done_i,
    input  logic [7:0]             DataReceived_i,
    output logic [7:0]             DataToSend_o,
    input  logic                   LocalWrite_i,
    input  logic [ADDR_W-1:0]      LocalAddr_i,
    input  logic [7:0]             LocalData_i,
    output logic [8*REG_COUNT-1:0] Regs_o,
    output logic                   WriteStrobe_o,
    output logic [ADDR_W-1:0]      WriteAddr_o,
    output logic                   Error_o
);

    localparam logic [ADDR_W:0]   REG_LIMIT = (ADDR_W+1)'(REG_COUNT);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(REG_COUNT - 1);

    logic              cs_sync, cs_prev_q, armed_q;
    logic [1:0]        sync_age_q;
    logic              frame_start, frame_end;

    state_e            state_q;
    logic [ADDR_W-1:0] addr_q, waddr_q;
    logic [7:0]        miso_q;
    logic              wstrb_q, err_q;

    logic [ADDR_W-1:0] cmd_addr, addr_inc_d, rd_addr;
    logic              cmd_oor, spi_wr;
    logic [REG_COUNT-1:0][7:0] regs;
    logic [REG_COUNT:0][7:0]   rd_chain;
    logic [7:0]        rd_data;

    sync_2ff u_cs_sync (
        .Clock (Clock),
        .Reset (Reset),
        .d_i   (CS_i),
        .q_o   (cs_sync)
    );

    // A frame start is only honoured once CS has been seen high after reset,
    // so a reset in the middle of a frame does not restart that frame.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            cs_prev_q  <= 1'b1;
            sync_age_q <= 2'd0;
            armed_q    <= 1'b0;
        end else begin
            cs_prev_q <= cs_sync;
            if (sync_age_q != 2'd2)
                sync_age_q <= sync_age_q + 2'd1;
            if (sync_age_q == 2'd2 && cs_sync)
                armed_q <= 1'b1;
        end
    end

    assign frame_start = armed_q & cs_prev_q & ~cs_sync;
    assign frame_end   = ~cs_prev_q & cs_sync;

    assign cmd_addr   = DataReceived_i[CMD_ADDR_MSB:0];
    assign cmd_oor    = {1'b0, cmd_addr} >= REG_LIMIT;
    assign addr_inc_d = (addr_q == LAST_ADDR) ? '0 : addr_q + ADDR_W'(1);
    assign rd_addr    = (state_q == ST_CMD) ? cmd_addr : addr_inc_d;
    assign spi_wr     = (state_q == ST_WRITE) && Done_i;

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            miso_q  <= ID_BYTE;
            wstrb_q <= 1'b0;
            waddr_q <= '0;
            err_q   <= 1'b0;
        end else begin
            wstrb_q <= 1'b0;
            err_q   <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (frame_start) begin
                        state_q <= ST_CMD;
                        miso_q  <= ID_BYTE;
                    end
                end
                ST_CMD: begin
                    if (Done_i) begin
                        addr_q <= cmd_addr;
                        if (cmd_oor) begin
                            state_q <= ST_IGNORE;
                            err_q   <= 1'b1;
                            miso_q  <= OOR_BYTE;
                        end else if (DataReceived_i[CMD_RW_BIT]) begin
                            state_q <= ST_READ;
                            miso_q  <= rd_data;
                        end else begin
                            state_q <= ST_WRITE;
                        end
                    end
                end
                ST_WRITE: begin
                    if (Done_i) begin
                        wstrb_q <= 1'b1;
                        waddr_q <= addr_q;
                        addr_q  <= addr_inc_d;
                    end
                end
                ST_READ: begin
                    if (Done_i) begin
                        addr_q <= addr_inc_d;
                        miso_q <= rd_data;
                    end
                end
                ST_IGNORE: miso_q <= OOR_BYTE;
                default:   state_q <= ST_IDLE;
            endcase
            // Byte in the closing cycle is handled above; the frame end overrides state.
            if (frame_end) begin
                state_q <= ST_IDLE;
                miso_q  <= ID_BYTE;
            end
        end
    end

    assign rd_chain[0] = '0;

    for (genvar g = 0; g < REG_COUNT; g++) begin : g_reg
        localparam logic [ADDR_W-1:0] A = ADDR_W'(g);
        logic [7:0] reg_q;

        // SPI write has priority over a fabric write to the same register.
        always_ff @(posedge Clock or negedge Reset) begin
            if (!Reset)
                reg_q <= '0;
            else if (spi_wr && addr_q == A)
                reg_q <= DataReceived_i;
            else if (LocalWrite_i && LocalAddr_i == A)
                reg_q <= LocalData_i;
        end

        assign regs[g]       = reg_q;
        assign rd_chain[g+1] = rd_chain[g] | ((rd_addr == A) ? reg_q : 8'h00);
    end

    assign rd_data       = rd_chain[REG_COUNT];
    assign Regs_o        = regs;
    assign DataToSend_o  = miso_q;
    assign WriteStrobe_o = wstrb_q;
    assign WriteAddr_o   = waddr_q;
    assign Error_o       = err_q;

endmodule

// File: tb/tb_spi_reg_bank.sv
// Directed bench for spi_reg_bank; the SPI byte engine is modelled by Done_i pulses.
module tb_spi_reg_bank;

    logic         Clock = 1'b0;
    logic         Reset;
    logic         CS_i;
    logic         Done_i;
    logic [7:0]   DataReceived_i;
    logic [7:0]   DataToSend_o;
    logic         LocalWrite_i;
    logic [6:0]   LocalAddr_i;
    logic [7:0]   LocalData_i;
    logic [127:0] Regs_o;
    logic         WriteStrobe_o;
    logic [6:0]   WriteAddr_o;
    logic         Error_o;

    int checks   = 0;
    int failures = 0;
    int err_cnt  = 0;
    logic [6:0]   strobes[$];
    logic [127:0] exp_regs = '0;

    spi_reg_bank dut (
        .Clock          (Clock),
        .Reset          (Reset),
        .CS_i           (CS_i),
        .Done_i         (Done_i),
        .DataReceived_i (DataReceived_i),
        .DataToSend_o   (DataToSend_o),
        .LocalWrite_i   (LocalWrite_i),
        .LocalAddr_i    (LocalAddr_i),
        .LocalData_i    (LocalData_i),
        .Regs_o         (Regs_o),
        .WriteStrobe_o  (WriteStrobe_o),
        .WriteAddr_o    (WriteAddr_o),
        .Error_o        (Error_o)
    );

    always #5 Clock = ~Clock;

    always @(negedge Clock) begin
        if (WriteStrobe_o) strobes.push_back(WriteAddr_o);
        if (Error_o) err_cnt++;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge Clock);
    endtask

    task automatic frame_begin;
        CS_i = 1'b0;
        tick(6);
    endtask

    task automatic frame_finish;
        CS_i = 1'b1;
        tick(6);
    endtask

    // Returns the MISO byte presented while this byte is shifted in.
    task automatic xfer(input logic [7:0] b, output logic [7:0] miso);
        miso = DataToSend_o;
        DataReceived_i = b;
        Done_i = 1'b1;
        tick(1);
        Done_i = 1'b0;
        DataReceived_i = 8'h00;
        tick(4);
    endtask

    task automatic test_reset;
        Reset = 1'b0;
        CS_i = 1'b1;
        tick(3);
        checks++; if (DataToSend_o !== 8'hA5) begin failures++; $display("FAIL reset_miso got=%h exp=a5", DataToSend_o); end
        Reset = 1'b1;
        tick(4);
        checks++; if (Regs_o !== 128'h0) begin failures++; $display("FAIL reset_regs got=%h exp=0", Regs_o); end
        checks++; if (WriteStrobe_o !== 1'b0 || Error_o !== 1'b0) begin failures++; $display("FAIL reset_strobes got=%b%b exp=00", WriteStrobe_o, Error_o); end
        checks++; if (WriteAddr_o !== 7'd0) begin failures++; $display("FAIL reset_waddr got=%h exp=0", WriteAddr_o); end
    endtask

    task automatic test_idle_glitch;
        logic [7:0] m;
        strobes.delete();
        xfer(8'h05, m);
        xfer(8'h99, m);
        checks++; if (Regs_o !== exp_regs || strobes.size() != 0) begin failures++; $display("FAIL idle_glitch regs=%h strobes=%0d exp regs=%h strobes=0", Regs_o, strobes.size(), exp_regs); end
    endtask

    task automatic test_write;
        logic [7:0] m0, m1, m2;
        strobes.delete();
        frame_begin();
        xfer(8'h03, m0);
        xfer(8'h11, m1);
        xfer(8'h22, m2);
        frame_finish();
        exp_regs[8*3 +: 8] = 8'h11;
        exp_regs[8*4 +: 8] = 8'h22;
        checks++; if (m0 !== 8'hA5) begin failures++; $display("FAIL write_id got=%h exp=a5", m0); end
        checks++; if (Regs_o !== exp_regs) begin failures++; $display("FAIL write_regs got=%h exp=%h", Regs_o, exp_regs); end
        checks++; if (strobes.size() != 2) begin failures++; $display("FAIL write_strobe_cnt got=%0d exp=2", strobes.size()); end
        else begin
            checks++; if (strobes[0] !== 7'd3 || strobes[1] !== 7'd4) begin failures++; $display("FAIL write_strobe_addr got=%0d,%0d exp=3,4", strobes[0], strobes[1]); end
        end
    endtask

    task automatic test_read;
        logic [7:0] m0, m1, m2;
        strobes.delete();
        frame_begin();
        xfer(8'h83, m0);
        xfer(8'h00, m1);
        xfer(8'h00, m2);
        frame_finish();
        checks++; if (m0 !== 8'hA5 || m1 !== 8'h11 || m2 !== 8'h22) begin failures++; $display("FAIL read_miso got=%h,%h,%h exp=a5,11,22", m0, m1, m2); end
        checks++; if (DataToSend_o !== 8'hA5) begin failures++; $display("FAIL read_end_miso got=%h exp=a5", DataToSend_o); end
        checks++; if (Regs_o !== exp_regs || strobes.size() != 0) begin failures++; $display("FAIL read_side_effect regs=%h strobes=%0d", Regs_o, strobes.size()); end
    endtask

    task automatic test_wrap;
        logic [7:0] m0, m1, m2;
        strobes.delete();
        frame_begin();
        xfer(8'h0F, m0);
        xfer(8'hAA, m1);
        xfer(8'hBB, m2);
        frame_finish();
        exp_regs[8*15 +: 8] = 8'hAA;
        exp_regs[8*0 +: 8]  = 8'hBB;
        checks++; if (Regs_o !== exp_regs) begin failures++; $display("FAIL wrap_regs got=%h exp=%h", Regs_o, exp_regs); end
        checks++; if (strobes.size() != 2 || strobes[0] !== 7'd15 || strobes[1] !== 7'd0) begin failures++; $display("FAIL wrap_strobes cnt=%0d exp addrs 15,0", strobes.size()); end
        frame_begin();
        xfer(8'h8F, m0);
        xfer(8'h00, m1);
        xfer(8'h00, m2);
        frame_finish();
        checks++; if (m0 !== 8'hA5 || m1 !== 8'hAA || m2 !== 8'hBB) begin failures++; $display("FAIL wrap_read got=%h,%h,%h exp=a5,aa,bb", m0, m1, m2); end
    endtask

    task automatic test_out_of_range;
        logic [7:0] m0, m1;
        strobes.delete();
        err_cnt = 0;
        frame_begin();
        xfer(8'h20, m0);
        xfer(8'h55, m1);
        frame_finish();
        checks++; if (err_cnt != 1) begin failures++; $display("FAIL oor_error got=%0d exp=1", err_cnt); end
        checks++; if (m1 !== 8'hFF) begin failures++; $display("FAIL oor_miso got=%h exp=ff", m1); end
        checks++; if (Regs_o !== exp_regs || strobes.size() != 0) begin failures++; $display("FAIL oor_regs got=%h exp=%h strobes=%0d", Regs_o, exp_regs, strobes.size()); end
    endtask

    task automatic test_local_collision;
        logic [7:0] m;
        strobes.delete();
        frame_begin();
        xfer(8'h05, m);
        DataReceived_i = 8'h77; Done_i = 1'b1;
        LocalWrite_i = 1'b1; LocalAddr_i = 7'd5; LocalData_i = 8'h99;
        tick(1);
        Done_i = 1'b0; LocalWrite_i = 1'b0;
        tick(4);
        DataReceived_i = 8'h3C; Done_i = 1'b1;
        LocalWrite_i = 1'b1; LocalAddr_i = 7'd7; LocalData_i = 8'hC3;
        tick(1);
        Done_i = 1'b0; LocalWrite_i = 1'b0;
        tick(4);
        frame_finish();
        LocalWrite_i = 1'b1; LocalAddr_i = 7'd20; LocalData_i = 8'hEE;
        tick(1);
        LocalAddr_i = 7'd9; LocalData_i = 8'h5D;
        tick(1);
        LocalWrite_i = 1'b0;
        tick(2);
        exp_regs[8*5 +: 8] = 8'h77;
        exp_regs[8*6 +: 8] = 8'h3C;
        exp_regs[8*7 +: 8] = 8'hC3;
        exp_regs[8*9 +: 8] = 8'h5D;
        checks++; if (Regs_o[8*5 +: 8] !== 8'h77) begin failures++; $display("FAIL collide_spi_wins got=%h exp=77", Regs_o[8*5 +: 8]); end
        checks++; if (Regs_o !== exp_regs) begin failures++; $display("FAIL collide_regs got=%h exp=%h", Regs_o, exp_regs); end
        checks++; if (strobes.size() != 2 || strobes[0] !== 7'd5 || strobes[1] !== 7'd6) begin failures++; $display("FAIL collide_strobes cnt=%0d exp addrs 5,6", strobes.size()); end
    endtask

    task automatic test_done_at_frame_end;
        logic [7:0] m0, m1;
        strobes.delete();
        frame_begin();
        xfer(8'h08, m0);
        CS_i = 1'b1;
        tick(2);
        DataReceived_i = 8'h5A; Done_i = 1'b1;
        tick(1);
        Done_i = 1'b0; DataReceived_i = 8'h00;
        tick(4);
        exp_regs[8*8 +: 8] = 8'h5A;
        checks++; if (Regs_o !== exp_regs) begin failures++; $display("FAIL endbyte_regs got=%h exp=%h", Regs_o, exp_regs); end
        checks++; if (strobes.size() != 1 || strobes[0] !== 7'd8) begin failures++; $display("FAIL endbyte_strobe cnt=%0d exp one at 8", strobes.size()); end
        checks++; if (DataToSend_o !== 8'hA5) begin failures++; $display("FAIL endbyte_miso got=%h exp=a5", DataToSend_o); end
        frame_begin();
        xfer(8'h88, m0);
        xfer(8'h00, m1);
        frame_finish();
        checks++; if (m0 !== 8'hA5 || m1 !== 8'h5A) begin failures++; $display("FAIL endbyte_next_frame got=%h,%h exp=a5,5a", m0, m1); end
    endtask

    task automatic test_reset_midframe;
        logic [7:0] m0, m1;
        frame_begin();
        xfer(8'h01, m0);
        xfer(8'h44, m0);
        checks++; if (Regs_o[8*1 +: 8] !== 8'h44) begin failures++; $display("FAIL midrst_pre got=%h exp=44", Regs_o[8*1 +: 8]); end
        Reset = 1'b0;
        tick(2);
        Reset = 1'b1;
        tick(2);
        strobes.delete();
        exp_regs = '0;
        xfer(8'h66, m0);
        xfer(8'h77, m1);
        checks++; if (Regs_o !== exp_regs || strobes.size() != 0) begin failures++; $display("FAIL midrst_ignored regs=%h strobes=%0d exp regs=0", Regs_o, strobes.size()); end
        checks++; if (DataToSend_o !== 8'hA5) begin failures++; $display("FAIL midrst_miso got=%h exp=a5", DataToSend_o); end
        frame_finish();
        frame_begin();
        xfer(8'h02, m0);
        xfer(8'h12, m1);
        frame_finish();
        exp_regs[8*2 +: 8] = 8'h12;
        checks++; if (Regs_o !== exp_regs) begin failures++; $display("FAIL midrst_next_frame got=%h exp=%h", Regs_o, exp_regs); end
        checks++; if (strobes.size() != 1 || strobes[0] !== 7'd2) begin failures++; $display("FAIL midrst_strobe cnt=%0d exp one at 2", strobes.size()); end
    endtask

    initial begin
        Reset = 1'b0;
        CS_i = 1'b1;
        Done_i = 1'b0;
        DataReceived_i = 8'h00;
        LocalWrite_i = 1'b0;
        LocalAddr_i = 7'd0;
        LocalData_i = 8'h00;
        tick(1);
        test_reset();
        test_idle_glitch();
        test_write();
        test_read();
        test_wrap();
        test_out_of_range();
        test_local_collision();
        test_done_at_frame_end();
        test_reset_midframe();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
